// File: rtl/cfglut_k.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cfglut_k
// Purpose  : Runtime-reconfigurable K-input LUT with dual O5/O6 outputs, a
//            serial configuration shift chain and a counted reload sequencer.
//            The truth table lives in a register that reset restores to INIT.
//            A whole-table reload started by LD is tracked with BUSY/DONE.
// Params   : K    - number of LUT inputs (2..6), table size N = 2**K
//            INIT - reset truth table, bits [N-1:0] used
// Ports    : CLK  - clock, rising edge
//            RST  - synchronous active-high reset
//            CE   - shift enable, one table shift per cycle
//            CDI  - serial configuration data in
//            LD   - reload start strobe (sampled in IDLE only)
//            I    - LUT address
//            O5   - half-table output TBL[{0, I[K-2:0]}]
//            O6   - full-table output TBL[I]
//            CDO  - serial data out, TBL[N-1]
//            BUSY - reload in progress
//            DONE - one-cycle pulse when a reload completes
// Options  : CFGLUT_K_OREG_EN - when defined, O5/O6 are registered (reset 0)
// Revision : 1.0 - initial release
// ============================================================================
module cfglut_k #(
    parameter int          K    = 5,
    parameter logic [63:0] INIT = 64'h0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CE,
    input  logic         CDI,
    input  logic         LD,
    input  logic [K-1:0] I,
    output logic         O5,
    output logic         O6,
    output logic         CDO,
    output logic         BUSY,
    output logic         DONE
);

    localparam int         C_N     = 1 << K;
    localparam logic [K:0] C_N_CNT = (K+1)'(C_N);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [C_N-1:0] r_tbl;
    logic [K:0]     r_cnt;
    logic [K:0]     w_cnt_nxt;
    logic           r_done;
    logic           w_done_nxt;
    logic [K-1:0]   w_o5_idx;
    logic           w_o5;
    logic           w_o6;

    // Table shift is free-running on CE regardless of sequencer state; the
    // sequencer only observes and counts the shifts.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_tbl <= INIT[C_N-1:0];
        end else if (CE) begin
            r_tbl <= {r_tbl[C_N-2:0], CDI};
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (LD) begin
                    w_state_nxt = ST_LOAD;
                    // A shift on the LD edge itself is the first counted one.
                    w_cnt_nxt   = CE ? (K+1)'(1) : '0;
                end
            end
            ST_LOAD: begin
                // LD is ignored here; CE low simply stalls the count.
                if (CE) begin
                    w_cnt_nxt = r_cnt + (K+1)'(1);
                    if (w_cnt_nxt == C_N_CNT) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // O5 looks only at the lower half of the table.
    assign w_o5_idx = {1'b0, I[K-2:0]};
    assign w_o5     = r_tbl[w_o5_idx];
    assign w_o6     = r_tbl[I];

`ifdef CFGLUT_K_OREG_EN
    logic r_o5;
    logic r_o6;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_o5 <= 1'b0;
            r_o6 <= 1'b0;
        end else begin
            r_o5 <= w_o5;
            r_o6 <= w_o6;
        end
    end

    assign O5 = r_o5;
    assign O6 = r_o6;
`else
    assign O5 = w_o5;
    assign O6 = w_o6;
`endif

    assign CDO  = r_tbl[C_N-1];
    assign BUSY = (r_state == ST_LOAD);
    assign DONE = r_done;

endmodule
`default_nettype wire

// File: tb/tb_cfglut_k.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cfglut_k
// Purpose  : Self-checking bench for cfglut_k. Three instances (K=6, K=5,
//            K=4) cover table readout, free shifting, reloads with and
//            without CE stalls, and reset during a reload. A K=3 instance
//            covers registered outputs when CFGLUT_K_OREG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cfglut_k;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       ce6, cdi6, ld6;
    logic [5:0] i6;
    logic       o5_6, o6_6, cdo6, busy6, done6;

    logic       ce5, cdi5, ld5;
    logic [4:0] i5;
    logic       o5_5, o6_5, cdo5, busy5, done5;

    logic       ce4, cdi4, ld4;
    logic [3:0] i4;
    logic       o5_4, o6_4, cdo4, busy4, done4;

    cfglut_k #(.K(6), .INIT(64'hFEDC_BA98_7654_3210)) u_lut6 (
        .CLK(clk), .RST(rst), .CE(ce6), .CDI(cdi6), .LD(ld6), .I(i6),
        .O5(o5_6), .O6(o6_6), .CDO(cdo6), .BUSY(busy6), .DONE(done6)
    );

    cfglut_k #(.K(5), .INIT(64'h0000_0000_DEAD_BEEF)) u_lut5 (
        .CLK(clk), .RST(rst), .CE(ce5), .CDI(cdi5), .LD(ld5), .I(i5),
        .O5(o5_5), .O6(o6_5), .CDO(cdo5), .BUSY(busy5), .DONE(done5)
    );

    cfglut_k #(.K(4), .INIT(64'h0)) u_lut4 (
        .CLK(clk), .RST(rst), .CE(ce4), .CDI(cdi4), .LD(ld4), .I(i4),
        .O5(o5_4), .O6(o6_4), .CDO(cdo4), .BUSY(busy4), .DONE(done4)
    );

`ifdef CFGLUT_K_OREG_EN
    logic       ce3, cdi3, ld3;
    logic [2:0] i3;
    logic       o5_3, o6_3, cdo3, busy3, done3;

    cfglut_k #(.K(3), .INIT(64'h80)) u_lut3 (
        .CLK(clk), .RST(rst), .CE(ce3), .CDI(cdi3), .LD(ld3), .I(i3),
        .O5(o5_3), .O6(o6_3), .CDO(cdo3), .BUSY(busy3), .DONE(done3)
    );
`endif

    int checks = 0;
    int errors = 0;

    logic [63:0] c_init6 = 64'hFEDC_BA98_7654_3210;
    logic [31:0] c_init5 = 32'hDEAD_BEEF;

    typedef struct packed {
        logic busy;
        logic done;
        logic cdo;
    } sq_t;

    typedef struct packed {
        logic o6;
        logic o5;
    } ob_t;

    sq_t q4[$];
    sq_t q5[$];
    ob_t qo[$];
    logic qb[$];

    // Reference model of the K=4 instance: table plus reload sequencer.
    logic [15:0] m_tbl;
    logic        m_load;
    int          m_cnt;

    function void model4_reset();
        m_tbl  = 16'h0;
        m_load = 1'b0;
        m_cnt  = 0;
    endfunction

    function void model4_edge(input logic ce, input logic cdi, input logic ld);
        sq_t s;
        logic d;
        d = 1'b0;
        if (!m_load) begin
            if (ld) begin
                m_load = 1'b1;
                m_cnt  = ce ? 1 : 0;
            end
        end else if (ce) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == 16) begin
                m_load = 1'b0;
                d      = 1'b1;
            end
        end
        if (ce) m_tbl = {m_tbl[14:0], cdi};
        s.busy = m_load;
        s.done = d;
        s.cdo  = m_tbl[15];
        q4.push_back(s);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ce6 = 0; ld6 = 0; cdi6 = 0;
        ce5 = 0; ld5 = 0; cdi5 = 0;
        ce4 = 0; ld4 = 0; cdi4 = 0;
`ifdef CFGLUT_K_OREG_EN
        ce3 = 0; ld3 = 0; cdi3 = 0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model4_reset();
        q4.delete();
        q5.delete();
    endtask

    task automatic test_reset();
        i6 = 6'd63;
        i5 = '0;
        i4 = '0;
        do_reset();
        checks++;
        if (cdo6 !== 1'b1) begin errors++; $display("FAIL reset_cdo6 got %0b exp 1", cdo6); end
        checks++;
        if (busy6 !== 1'b0 || done6 !== 1'b0) begin
            errors++; $display("FAIL reset_busy_done6 got %0b/%0b exp 0/0", busy6, done6);
        end
        checks++;
        if (cdo5 !== 1'b1) begin errors++; $display("FAIL reset_cdo5 got %0b exp 1", cdo5); end
        checks++;
        if (cdo4 !== 1'b0 || busy4 !== 1'b0 || busy5 !== 1'b0) begin
            errors++; $display("FAIL reset_k4k5 got cdo4=%0b busy4=%0b busy5=%0b exp 0/0/0", cdo4, busy4, busy5);
        end
`ifdef CFGLUT_K_OREG_EN
        checks++;
        if (o6_6 !== 1'b0 || o5_6 !== 1'b0) begin
            errors++; $display("FAIL reset_oreg6 got o6=%0b o5=%0b exp 0/0", o6_6, o5_6);
        end
`else
        checks++;
        if (o6_6 !== 1'b1 || o5_6 !== 1'b0) begin
            errors++; $display("FAIL reset_comb6 got o6=%0b o5=%0b exp 1/0", o6_6, o5_6);
        end
`endif
    endtask

    task automatic test_sweep6();
        ob_t e;
        for (int i = 0; i < 64; i++) begin
            i6 = 6'(i);
            e.o6 = c_init6[i];
            e.o5 = c_init6[i & 31];
            qo.push_back(e);
            @(negedge clk);
            e = qo.pop_front();
            checks++;
            if (o6_6 !== e.o6 || o5_6 !== e.o5) begin
                errors++;
                $display("FAIL sweep6 I=%0d got o6=%0b o5=%0b exp %0b/%0b", i, o6_6, o5_6, e.o6, e.o5);
            end
        end
        checks++;
        if (cdo6 !== 1'b1 || busy6 !== 1'b0 || done6 !== 1'b0) begin
            errors++; $display("FAIL sweep6_status got cdo=%0b busy=%0b done=%0b exp 1/0/0", cdo6, busy6, done6);
        end
    endtask

    task automatic sweep4(input logic [15:0] exp_tbl, input string tag);
        logic b;
        ce4 = 1'b0;
        ld4 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            i4 = 4'(i);
            qb.push_back(exp_tbl[i]);
            @(negedge clk);
            b = qb.pop_front();
            checks++;
            if (o6_4 !== b) begin
                errors++; $display("FAIL %s_o6 I=%0d got %0b exp %0b", tag, i, o6_4, b);
            end
        end
    endtask

    task automatic test_free_shift();
        sq_t s;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            ce4  = (k < 3);
            cdi4 = 1'b1;
            ld4  = 1'b0;
            model4_edge(ce4, cdi4, ld4);
            @(negedge clk);
            s = q4.pop_front();
            checks++;
            if (busy4 !== s.busy || done4 !== s.done || cdo4 !== s.cdo) begin
                errors++;
                $display("FAIL free_shift k=%0d got busy=%0b done=%0b cdo=%0b exp %0b/%0b/%0b",
                         k, busy4, done4, cdo4, s.busy, s.done, s.cdo);
            end
        end
        sweep4(16'h0007, "free_shift");
    endtask

    task automatic test_reload();
        sq_t s;
        logic [15:0] pat;
        int done_seen;
        pat = 16'hA5C3;
        done_seen = 0;
        do_reset();
        for (int k = 0; k < 18; k++) begin
            ce4  = (k < 16);
            ld4  = (k == 0);
            cdi4 = (k < 16) ? pat[15-k] : 1'b0;
            model4_edge(ce4, cdi4, ld4);
            @(negedge clk);
            s = q4.pop_front();
            if (done4 === 1'b1) done_seen++;
            checks++;
            if (busy4 !== s.busy || done4 !== s.done || cdo4 !== s.cdo) begin
                errors++;
                $display("FAIL reload k=%0d got busy=%0b done=%0b cdo=%0b exp %0b/%0b/%0b",
                         k, busy4, done4, cdo4, s.busy, s.done, s.cdo);
            end
        end
        checks++;
        if (done_seen != 1) begin
            errors++; $display("FAIL reload_done_pulses got %0d exp 1", done_seen);
        end
        sweep4(pat, "reload");
    endtask

    task automatic test_stall_reload();
        sq_t s;
        logic [15:0] pat;
        int sh;
        int done_seen;
        pat = 16'h3C96;
        sh = 0;
        done_seen = 0;
        do_reset();
        for (int j = 0; j < 36; j++) begin
            ce4  = ((j % 2) == 0) && (sh < 16);
            ld4  = (j == 0) || (j == 9);
            cdi4 = ce4 ? pat[15-sh] : 1'b0;
            if (ce4) sh++;
            model4_edge(ce4, cdi4, ld4);
            @(negedge clk);
            s = q4.pop_front();
            if (done4 === 1'b1) done_seen++;
            checks++;
            if (busy4 !== s.busy || done4 !== s.done || cdo4 !== s.cdo) begin
                errors++;
                $display("FAIL stall_reload j=%0d got busy=%0b done=%0b cdo=%0b exp %0b/%0b/%0b",
                         j, busy4, done4, cdo4, s.busy, s.done, s.cdo);
            end
        end
        checks++;
        if (done_seen != 1) begin
            errors++; $display("FAIL stall_reload_done_pulses got %0d exp 1", done_seen);
        end
        sweep4(pat, "stall_reload");
    endtask

    task automatic test_reset_mid_reload();
        sq_t s;
        logic b;
        logic [31:0] pat;
        logic [31:0] m5;
        pat = 32'h1234_5678;
        do_reset();
        for (int k = 0; k < 10; k++) begin
            ce5  = 1'b1;
            ld5  = (k == 0);
            cdi5 = 1'b0;
            @(negedge clk);
            checks++;
            if (busy5 !== 1'b1 || done5 !== 1'b0) begin
                errors++; $display("FAIL mid_load k=%0d got busy=%0b done=%0b exp 1/0", k, busy5, done5);
            end
        end
        // Reset wins over CE and LD on the same edge.
        rst = 1'b1;
        ce5 = 1'b1;
        ld5 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ce5 = 1'b0;
        ld5 = 1'b0;
        checks++;
        if (busy5 !== 1'b0 || done5 !== 1'b0 || cdo5 !== 1'b1) begin
            errors++; $display("FAIL mid_rst got busy=%0b done=%0b cdo=%0b exp 0/0/1", busy5, done5, cdo5);
        end
        @(negedge clk);
        checks++;
        if (busy5 !== 1'b0 || done5 !== 1'b0) begin
            errors++; $display("FAIL mid_rst_after got busy=%0b done=%0b exp 0/0", busy5, done5);
        end
        for (int i = 0; i < 32; i++) begin
            i5 = 5'(i);
            qb.push_back(c_init5[i]);
            @(negedge clk);
            b = qb.pop_front();
            checks++;
            if (o6_5 !== b) begin
                errors++; $display("FAIL mid_rst_tbl I=%0d got %0b exp %0b", i, o6_5, b);
            end
        end
        m5 = c_init5;
        for (int k = 0; k < 34; k++) begin
            ce5  = (k < 32);
            ld5  = (k == 0);
            cdi5 = (k < 32) ? pat[31-k] : 1'b0;
            if (ce5) m5 = {m5[30:0], cdi5};
            s.busy = (k < 31);
            s.done = (k == 31);
            s.cdo  = m5[31];
            q5.push_back(s);
            @(negedge clk);
            s = q5.pop_front();
            checks++;
            if (busy5 !== s.busy || done5 !== s.done || cdo5 !== s.cdo) begin
                errors++;
                $display("FAIL reload5 k=%0d got busy=%0b done=%0b cdo=%0b exp %0b/%0b/%0b",
                         k, busy5, done5, cdo5, s.busy, s.done, s.cdo);
            end
        end
        ce5 = 1'b0;
        ld5 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            i5 = 5'(i);
            qb.push_back(pat[i]);
            @(negedge clk);
            b = qb.pop_front();
            checks++;
            if (o6_5 !== b) begin
                errors++; $display("FAIL reload5_tbl I=%0d got %0b exp %0b", i, o6_5, b);
            end
        end
    endtask

`ifdef CFGLUT_K_OREG_EN
    task automatic test_oreg();
        i3 = 3'd7;
        do_reset();
        checks++;
        if (o6_3 !== 1'b0 || o5_3 !== 1'b0) begin
            errors++; $display("FAIL oreg_rst got o6=%0b o5=%0b exp 0/0", o6_3, o5_3);
        end
        @(negedge clk);
        checks++;
        if (o6_3 !== 1'b1) begin errors++; $display("FAIL oreg_first got %0b exp 1", o6_3); end
        i3 = 3'd0;
        @(negedge clk);
        i3 = 3'd7;
        #1;
        checks++;
        if (o6_3 !== 1'b0) begin errors++; $display("FAIL oreg_hold got %0b exp 0", o6_3); end
        @(negedge clk);
        checks++;
        if (o6_3 !== 1'b1) begin errors++; $display("FAIL oreg_rise got %0b exp 1", o6_3); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst  = 1'b1;
        ce6 = 0; ld6 = 0; cdi6 = 0; i6 = '0;
        ce5 = 0; ld5 = 0; cdi5 = 0; i5 = '0;
        ce4 = 0; ld4 = 0; cdi4 = 0; i4 = '0;
`ifdef CFGLUT_K_OREG_EN
        ce3 = 0; ld3 = 0; cdi3 = 0; i3 = '0;
`endif
        test_reset();
        test_sweep6();
        test_free_shift();
        test_reload();
        test_stall_reload();
        test_reset_mid_reload();
`ifdef CFGLUT_K_OREG_EN
        test_oreg();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
